// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory-access pipeline stage.
//   - Funct3 access size/sign codes (RV32I loads/stores)
//   - ResultSrc write-back select codes
//   - FSM state type for the data-memory handshake
//   - misaligned(): size/offset legality check used by the alignment unit
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Access size comes from funct3[1:0]; the unused size code 11 is treated as a word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic m;
    case (f3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = addr_lo[0];
      default: m = (addr_lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: purely combinational RV32I byte-lane alignment.
// Ports:
//   i_Addr_Lo     [1:0]  low address bits selecting the byte lane
//   i_Funct3      [2:0]  access size/sign
//   i_Store_Data  [XLEN] rs2 value to be stored
//   i_Rdata       [XLEN] raw word returned by data memory
//   o_Be          [3:0]  byte enables of the addressed lanes
//   o_Wdata       [XLEN] store data replicated across all lanes
//   o_Load_Data   [XLEN] extracted and sign/zero-extended load value
//   o_Misaligned  1      access size and offset are incompatible
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_Addr_Lo,
  input  logic [2:0]      i_Funct3,
  input  logic [XLEN-1:0] i_Store_Data,
  input  logic [XLEN-1:0] i_Rdata,
  output logic [3:0]      o_Be,
  output logic [XLEN-1:0] o_Wdata,
  output logic [XLEN-1:0] o_Load_Data,
  output logic            o_Misaligned
);

  logic [7:0]  w_lbyte;
  logic [15:0] w_lhalf;

  // Store lane generation: replicate the narrow datum so any lane the byte enables pick is correct
  always_comb begin
    case (i_Funct3[1:0])
      2'b00: begin
        o_Be    = 4'b0001 << i_Addr_Lo;
        o_Wdata = {4{i_Store_Data[7:0]}};
      end
      2'b01: begin
        o_Be    = 4'b0011 << {i_Addr_Lo[1], 1'b0};
        o_Wdata = {2{i_Store_Data[15:0]}};
      end
      default: begin
        o_Be    = 4'b1111;
        o_Wdata = i_Store_Data;
      end
    endcase
  end

  // Load lane selection followed by sign or zero extension
  always_comb begin
    case (i_Addr_Lo)
      2'b00:   w_lbyte = i_Rdata[7:0];
      2'b01:   w_lbyte = i_Rdata[15:8];
      2'b10:   w_lbyte = i_Rdata[23:16];
      default: w_lbyte = i_Rdata[31:24];
    endcase
    if (i_Addr_Lo[1]) begin
      w_lhalf = i_Rdata[31:16];
    end else begin
      w_lhalf = i_Rdata[15:0];
    end
    case (i_Funct3)
      F3_B:    o_Load_Data = {{24{w_lbyte[7]}}, w_lbyte};
      F3_BU:   o_Load_Data = {24'd0, w_lbyte};
      F3_H:    o_Load_Data = {{16{w_lhalf[15]}}, w_lhalf};
      F3_HU:   o_Load_Data = {16'd0, w_lhalf};
      default: o_Load_Data = i_Rdata;
    endcase
  end

  // Misalignment check shared with the package helper
  always_comb begin
    o_Misaligned = misaligned(i_Funct3, i_Addr_Lo);
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access pipeline stage owning the MEM/WB register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_Valid .. i_Pc_4          EX/MEM entry (control, result/address, store data, funct3, PC+4)
//   o_Dmem_Req/We/Addr/Wdata/Be  single-port data-memory request (combinational)
//   i_Dmem_Ack, i_Dmem_Rdata   access completion and read word
//   o_Stall                    freeze upstream while an access is outstanding
//   o_RegSrc .. o_Pc_4         registered MEM/WB fields
//   o_Misaligned, o_Bus_Err    one-cycle pulses for dropped / timed-out accesses
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_Valid,
  input  logic            i_RegSrc,
  input  logic [4:0]      i_Rd,
  input  logic [1:0]      i_ResultSrc,
  input  logic [XLEN-1:0] i_Result,
  input  logic [XLEN-1:0] i_Store_Data,
  input  logic            i_MemRead,
  input  logic            i_MemWrite,
  input  logic [2:0]      i_Funct3,
  input  logic [XLEN-1:0] i_Pc_4,
  output logic            o_Dmem_Req,
  output logic            o_Dmem_We,
  output logic [XLEN-1:0] o_Dmem_Addr,
  output logic [XLEN-1:0] o_Dmem_Wdata,
  output logic [3:0]      o_Dmem_Be,
  input  logic            i_Dmem_Ack,
  input  logic [XLEN-1:0] i_Dmem_Rdata,
  output logic            o_Stall,
  output logic            o_RegSrc,
  output logic [4:0]      o_Rd,
  output logic [1:0]      o_ResultSrc,
  output logic [XLEN-1:0] o_Result,
  output logic [XLEN-1:0] o_Wb_Data,
  output logic [XLEN-1:0] o_Pc_4,
  output logic            o_Misaligned,
  output logic            o_Bus_Err
);

  // The counter holds how many request cycles have already elapsed, so the
  // access is abandoned on its ACK_TIMEOUT-th request cycle.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_cnt;

  logic            w_memop;
  logic            w_misal;
  logic            w_req;
  logic            w_done;
  logic            w_timeout;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;
  logic            w_align_misal;

  mem_align #(.XLEN(XLEN)) u_align (
    .i_Addr_Lo    (i_Result[1:0]),
    .i_Funct3     (i_Funct3),
    .i_Store_Data (i_Store_Data),
    .i_Rdata      (i_Dmem_Rdata),
    .o_Be         (w_be),
    .o_Wdata      (w_wdata),
    .o_Load_Data  (w_load_data),
    .o_Misaligned (w_align_misal)
  );

  // Request, completion, timeout and stall decode; rst_n gating drops the request asynchronously
  always_comb begin
    w_memop = i_Valid & (i_MemRead | i_MemWrite);
    w_misal = w_memop & w_align_misal;
    if (r_state == ST_WAIT) begin
      w_req = rst_n;
    end else begin
      w_req = rst_n & w_memop & ~w_misal;
    end
    w_done    = w_req & i_Dmem_Ack;
    w_timeout = w_req & ~i_Dmem_Ack & (r_cnt == TMO_LAST);
    o_Stall   = w_req & ~i_Dmem_Ack & ~w_timeout;
  end

  // Data-memory request fields, driven only while a request is active
  always_comb begin
    if (w_req) begin
      o_Dmem_Req   = 1'b1;
      o_Dmem_We    = i_MemWrite;
      o_Dmem_Addr  = {i_Result[XLEN-1:2], 2'b00};
      o_Dmem_Be    = w_be;
      o_Dmem_Wdata = i_MemWrite ? w_wdata : {XLEN{1'b0}};
    end else begin
      o_Dmem_Req   = 1'b0;
      o_Dmem_We    = 1'b0;
      o_Dmem_Addr  = {XLEN{1'b0}};
      o_Dmem_Be    = 4'b0000;
      o_Dmem_Wdata = {XLEN{1'b0}};
    end
  end

  // Handshake FSM, timeout counter and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      o_RegSrc     <= 1'b0;
      o_Rd         <= 5'd0;
      o_ResultSrc  <= 2'b00;
      o_Result     <= {XLEN{1'b0}};
      o_Wb_Data    <= {XLEN{1'b0}};
      o_Pc_4       <= {XLEN{1'b0}};
      o_Misaligned <= 1'b0;
      o_Bus_Err    <= 1'b0;
    end else begin
      if (w_done || w_timeout) begin
        r_state <= ST_IDLE;
        r_cnt   <= 8'd0;
      end else if (w_req) begin
        r_state <= ST_WAIT;
        r_cnt   <= r_cnt + 8'd1;
      end else begin
        r_state <= ST_IDLE;
        r_cnt   <= 8'd0;
      end

      o_Misaligned <= w_misal & ~w_req;
      o_Bus_Err    <= w_timeout;

      // Only a completed access or a plain valid instruction reaches write-back;
      // stall cycles, timeouts, misaligned drops and bubbles all capture zeros.
      if (w_done || (i_Valid && !w_memop && !w_req)) begin
        o_RegSrc    <= i_RegSrc;
        o_Rd        <= i_Rd;
        o_ResultSrc <= i_ResultSrc;
        o_Result    <= i_Result;
        o_Pc_4      <= i_Pc_4;
        o_Wb_Data   <= (w_done && i_MemRead) ? w_load_data : {XLEN{1'b0}};
      end else begin
        o_RegSrc    <= 1'b0;
        o_Rd        <= 5'd0;
        o_ResultSrc <= 2'b00;
        o_Result    <= {XLEN{1'b0}};
        o_Pc_4      <= {XLEN{1'b0}};
        o_Wb_Data   <= {XLEN{1'b0}};
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly upstream of the write-back stage; owns the MEM/WB pipeline register.
- Drives a single-port data-memory request/acknowledge interface and performs RV32I byte-lane alignment: store byte-enables and data replication, load extraction with sign or zero extension.
- Stalls the pipeline while an access is outstanding.
- Passes non-memory instructions to write-back with one-cycle latency.

Parameters:
- XLEN, 32, datapath width.
- ACK_TIMEOUT, 16, maximum cycles to wait for i_Dmem_Ack before aborting the access (range 1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_Valid  in  1  EX/MEM entry holds a real instruction
- i_RegSrc  in  1  register write enable
- i_Rd  in  5  destination register
- i_ResultSrc  in  2  write-back select (00 ALU, 01 memory, 10 PC+4)
- i_Result  in  XLEN  ALU result; also the memory address
- i_Store_Data  in  XLEN  rs2 value for stores
- i_MemRead  in  1  load
- i_MemWrite  in  1  store
- i_Funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- i_Pc_4  in  XLEN  PC+4
- o_Dmem_Req  out  1  memory request
- o_Dmem_We  out  1  write strobe
- o_Dmem_Addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- o_Dmem_Wdata  out  XLEN  lane-replicated store data
- o_Dmem_Be  out  4  byte enables
- i_Dmem_Ack  in  1  access complete; read data valid this cycle
- i_Dmem_Rdata  in  XLEN  raw read word
- o_Stall  out  1  freeze upstream stages
- o_RegSrc, o_Rd, o_ResultSrc, o_Result, o_Wb_Data, o_Pc_4  out  1/5/2/XLEN/XLEN/XLEN  registered MEM/WB outputs
- o_Misaligned  out  1  one-cycle pulse: misaligned access dropped
- o_Bus_Err  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0, all registered outputs 0, o_Misaligned=0, o_Bus_Err=0. Combinational o_Dmem_Req and o_Stall are 0 while in reset.
- Memory op: memop = i_Valid & (i_MemRead | i_MemWrite).
- Misalignment:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=00 is misaligned.
  - Result: no request, MEM/WB captures a bubble (o_RegSrc=0), o_Misaligned pulses next cycle, no stall.
- FSM states:
  - IDLE: an aligned memop drives o_Dmem_Req=1 combinationally in the same cycle. If i_Dmem_Ack=1 that cycle, the access completes with zero wait. Otherwise go to WAIT with o_Stall=1.
  - WAIT: hold o_Dmem_Req=1 with a stable address, data and byte-enables; the upstream stage holds its inputs because o_Stall=1. The counter increments each cycle.
    - On i_Dmem_Ack: o_Stall drops that cycle, the result is captured, return to IDLE.
    - On counter == ACK_TIMEOUT-1 without ack: drop the request, capture a bubble, pulse o_Bus_Err, return to IDLE.
- Ack precedence: an ack arriving in the timeout cycle wins; the access completes normally.
- While stalled, MEM/WB captures a bubble each cycle (o_RegSrc=0) so write-back never writes twice.
- Stores:
  - SB: Be = 0001<<addr[1:0]; Wdata = byte replicated ×4.
  - SH: Be = 0011<<{addr[1],1'b0}; Wdata = half replicated ×2.
  - SW: Be = 1111.
  - o_Dmem_We=1.
  - A store captures o_RegSrc as given (normally 0).
- Loads: select the byte or half lane by addr[1:0]. Sign-extend for B/H, zero-extend for BU/HU. Result goes to o_Wb_Data.
- Non-memory valid instruction: all fields registered in one cycle, o_Wb_Data=0.
- i_Valid=0: bubble captured.
- If i_Dmem_Ack arrives while no request is outstanding, it is ignored.
- Reset asserted mid-WAIT: return to IDLE immediately, request dropped, outputs cleared.

Decomposition:
- Shared package:
  - Funct3 load/store size encodings.
  - ResultSrc encodings (ALU/MEM/PC4).
  - FSM state encoding.
- One natural sub-module: mem_align. Purely combinational store lane/byte-enable generation, load extraction/extension, and the misalignment check. The FSM, counter and MEM/WB register stay in mem_stage.

Test Plan:
- LW at 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> o_Stall high 3 cycles; o_Wb_Data=0xDEADBEEF with o_RegSrc=1 exactly once; bubbles during the stall.
- LB at 0x103, rdata 0x80FF1234, zero-wait ack -> o_Wb_Data=0xFFFFFF80; LBU at the same address -> 0x00000080; no stall.
- SH at 0x202, data 0x0000ABCD -> o_Dmem_Be=1100, o_Dmem_Wdata=0xABCDABCD, o_Dmem_Addr=0x200, o_Dmem_We=1.
- LW at 0x101 -> no o_Dmem_Req; o_Misaligned pulse; o_RegSrc=0 next cycle.
- LW with no ack and ACK_TIMEOUT=16 -> request held exactly 16 cycles; o_Bus_Err pulse; stall released; bubble captured.
- ADD with i_Result=0x5, i_Rd=7 -> next cycle o_Result=5, o_Rd=7, o_RegSrc=1. Asserting rst_n=0 during a WAIT clears all outputs and drops o_Dmem_Req asynchronously.
